// File: rtl/hs_arbiter.sv
// Round-robin arbiter feeding one 4-phase bundled-data channel from NREQ
// clocked valid/ready requesters; the channel acknowledge is synchronised locally.
module hs_arbiter #(
   parameter int             NREQ     = 4,
   parameter int             N        = 8,
   parameter int             SYNC     = 2,
   parameter int             SETUP    = 1,
   parameter logic [N-1:0]   RdataVal = '0,
   localparam int            PW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_v,
   output logic [NREQ-1:0]      req_rdy,
   input  logic [NREQ*N-1:0]    req_d,
   output logic                 r_o,
   input  logic                 a_o,
   output logic [N-1:0]         d_o,
   output logic [PW-1:0]        grant_id,
   output logic                 busy
);

   localparam int PW1 = PW + 1;
   localparam int CW  = (SETUP > 1) ? $clog2(SETUP) : 1;

   if (SETUP < 1) begin : g_bad_setup
      $error("hs_arbiter: SETUP must be at least 1");
   end
   if (SYNC < 2) begin : g_bad_sync
      $error("hs_arbiter: SYNC must be at least 2");
   end
   if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
      $error("hs_arbiter: NREQ must be in 2..16");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_REQ,
      ST_REL
   } state_t;

   state_t          state, state_n;
   logic [SYNC-1:0] sync_q;
   logic [SYNC-1:0] warm_q;
   logic            ack_s;
   logic            sync_ok;
   logic [PW-1:0]   ptr_q;
   logic [PW-1:0]   win;
   logic [PW1-1:0]  idx;
   logic [N-1:0]    win_d;
   logic            win_vld;
   logic            grant;
   logic [CW-1:0]   cnt_q, cnt_n;
   logic            r_n;

   assign ack_s   = sync_q[SYNC-1];
   // Grants wait until the synchroniser has been refilled after reset, so an
   // acknowledge still high at reset exit is seen before anything is granted.
   assign sync_ok = warm_q[SYNC-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
         warm_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC-2:0], a_o};
         warm_q <= {warm_q[SYNC-2:0], 1'b1};
      end
   end

   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      win_d   = '0;
      idx     = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = {1'b0, ptr_q} + PW1'(k);
         if (idx >= PW1'(NREQ)) begin
            idx = idx - PW1'(NREQ);
         end
         if (!win_vld && req_v[idx[PW-1:0]]) begin
            win     = idx[PW-1:0];
            win_vld = 1'b1;
         end
      end
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (PW'(k) == win) begin
            win_d = req_d[k*N +: N];
         end
      end
   end

   assign grant = (state == ST_IDLE) && sync_ok && !ack_s && win_vld;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         cnt_q    <= '0;
         r_o      <= 1'b0;
         d_o      <= RdataVal;
         grant_id <= '0;
         ptr_q    <= '0;
      end else begin
         state <= state_n;
         cnt_q <= cnt_n;
         r_o   <= r_n;
         if (grant) begin
            d_o      <= win_d;
            grant_id <= win;
            ptr_q    <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
         end
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt_q;
      r_n     = r_o;
      unique case (state)
         ST_IDLE: begin
            if (grant) begin
               state_n = ST_SETUP;
               cnt_n   = '0;
            end
         end
         ST_SETUP: begin
            if (cnt_q == CW'(SETUP - 1)) begin
               r_n     = 1'b1;
               state_n = ST_REQ;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         ST_REQ: begin
            if (ack_s) begin
               r_n     = 1'b0;
               state_n = ST_REL;
            end
         end
         ST_REL: begin
            if (!ack_s) begin
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      req_rdy = '0;
      if (grant) begin
         req_rdy[win] = 1'b1;
      end
      busy = (state != ST_IDLE);
   end

endmodule

// File: tb/tb_hs_arbiter.sv
// Directed bench for hs_arbiter: default build, a SETUP=3 build and an NREQ=3 build.
module tb_hs_arbiter;

   localparam int SYNC_T = 2;

   logic clk;
   logic rst;

   logic [3:0]  req_v, req_rdy;
   logic [31:0] req_d;
   logic        a_o, r_o, busy;
   logic [7:0]  d_o;
   logic [1:0]  grant_id;

   logic [3:0]  v3, rdy3;
   logic [31:0] d3;
   logic        a3, r3, busy3;
   logic [7:0]  do3;
   logic [1:0]  gid3;

   logic [2:0]  vn, rdyn;
   logic [23:0] dn;
   logic        an, rn, busyn;
   logic [7:0]  don;
   logic [1:0]  gidn;

   int unsigned pass_cnt = 0;
   int unsigned chk_cnt  = 0;

   hs_arbiter #(.NREQ(4), .N(8), .SYNC(SYNC_T), .SETUP(1), .RdataVal(8'h00)) u_dut (
      .clk(clk), .rst(rst), .req_v(req_v), .req_rdy(req_rdy), .req_d(req_d),
      .r_o(r_o), .a_o(a_o), .d_o(d_o), .grant_id(grant_id), .busy(busy));

   hs_arbiter #(.NREQ(4), .N(8), .SYNC(SYNC_T), .SETUP(3), .RdataVal(8'h00)) u_dut_s3 (
      .clk(clk), .rst(rst), .req_v(v3), .req_rdy(rdy3), .req_d(d3),
      .r_o(r3), .a_o(a3), .d_o(do3), .grant_id(gid3), .busy(busy3));

   hs_arbiter #(.NREQ(3), .N(8), .SYNC(SYNC_T), .SETUP(1), .RdataVal(8'h00)) u_dut_n3 (
      .clk(clk), .rst(rst), .req_v(vn), .req_rdy(rdyn), .req_d(dn),
      .r_o(rn), .a_o(an), .d_o(don), .grant_id(gidn), .busy(busyn));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      req_v = '0; req_d = '0; a_o = 1'b0;
      v3 = '0; d3 = '0; a3 = 1'b0;
      vn = '0; dn = '0; an = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   // Completes a handshake on the default build; rc counts cycles with req_rdy set while busy.
   task automatic hs_main(output bit to, output int unsigned rc);
      int unsigned n;
      to = 1'b0; rc = 0;
      n = 0;
      while (r_o !== 1'b1 && n < 40) begin if (req_rdy !== 4'b0) rc++; tick(); n++; end
      if (r_o !== 1'b1) to = 1'b1;
      a_o = 1'b1;
      n = 0;
      while (r_o !== 1'b0 && n < 40) begin if (req_rdy !== 4'b0) rc++; tick(); n++; end
      if (r_o !== 1'b0) to = 1'b1;
      a_o = 1'b0;
      n = 0;
      while (busy !== 1'b0 && n < 40) begin if (req_rdy !== 4'b0) rc++; tick(); n++; end
      if (busy !== 1'b0) to = 1'b1;
   endtask

   task automatic hs_s3(output bit to);
      int unsigned n;
      to = 1'b0;
      n = 0;
      while (r3 !== 1'b1 && n < 40) begin tick(); n++; end
      if (r3 !== 1'b1) to = 1'b1;
      a3 = 1'b1;
      n = 0;
      while (r3 !== 1'b0 && n < 40) begin tick(); n++; end
      if (r3 !== 1'b0) to = 1'b1;
      a3 = 1'b0;
      n = 0;
      while (busy3 !== 1'b0 && n < 40) begin tick(); n++; end
      if (busy3 !== 1'b0) to = 1'b1;
   endtask

   task automatic hs_n3(output bit to, output int unsigned rc);
      int unsigned n;
      to = 1'b0; rc = 0;
      n = 0;
      while (rn !== 1'b1 && n < 40) begin if (rdyn !== 3'b0) rc++; tick(); n++; end
      if (rn !== 1'b1) to = 1'b1;
      an = 1'b1;
      n = 0;
      while (rn !== 1'b0 && n < 40) begin if (rdyn !== 3'b0) rc++; tick(); n++; end
      if (rn !== 1'b0) to = 1'b1;
      an = 1'b0;
      n = 0;
      while (busyn !== 1'b0 && n < 40) begin if (rdyn !== 3'b0) rc++; tick(); n++; end
      if (busyn !== 1'b0) to = 1'b1;
   endtask

   task automatic test_reset();
      int unsigned n;
      idle_all();
      req_v = 4'b0100;
      req_d = 32'h00A5_0000;
      rst = 1'b0;
      tick(); tick();
      chk_cnt++; if (r_o !== 1'b0) $display("FAIL rst_r_o got=%b exp=0", r_o); else pass_cnt++;
      chk_cnt++; if (d_o !== 8'h00) $display("FAIL rst_d_o got=%h exp=00", d_o); else pass_cnt++;
      chk_cnt++; if (req_rdy !== 4'b0000) $display("FAIL rst_req_rdy got=%b exp=0000", req_rdy); else pass_cnt++;
      chk_cnt++; if (grant_id !== 2'd0) $display("FAIL rst_grant_id got=%0d exp=0", grant_id); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else pass_cnt++;
      rst = 1'b1;
      n = 0;
      while (req_rdy === 4'b0000 && n < 20) begin tick(); n++; end
      chk_cnt++; if (req_rdy !== 4'b0100) $display("FAIL t1_req_rdy got=%b exp=0100", req_rdy); else pass_cnt++;
      tick();
      req_v = 4'b0000;
      chk_cnt++; if (d_o !== 8'hA5) $display("FAIL t1_d_o got=%h exp=a5", d_o); else pass_cnt++;
      chk_cnt++; if (grant_id !== 2'd2) $display("FAIL t1_grant_id got=%0d exp=2", grant_id); else pass_cnt++;
      chk_cnt++; if (r_o !== 1'b0 || busy !== 1'b1) $display("FAIL t1_grant_edge r_o=%b busy=%b exp r_o=0 busy=1", r_o, busy); else pass_cnt++;
      tick();
      chk_cnt++; if (r_o !== 1'b1) $display("FAIL t1_r_rise got=%b exp=1", r_o); else pass_cnt++;
      repeat (3) tick();
      a_o = 1'b1;
      for (int i = 0; i < SYNC_T; i++) begin
         tick();
         chk_cnt++; if (r_o !== 1'b1) $display("FAIL t1_r_hold got=%b exp=1", r_o); else pass_cnt++;
      end
      tick();
      chk_cnt++; if (r_o !== 1'b0) $display("FAIL t1_r_fall got=%b exp=0", r_o); else pass_cnt++;
      a_o = 1'b0;
      for (int i = 0; i < SYNC_T; i++) begin
         tick();
         chk_cnt++; if (busy !== 1'b1) $display("FAIL t1_busy_hold got=%b exp=1", busy); else pass_cnt++;
      end
      tick();
      chk_cnt++; if (busy !== 1'b0) $display("FAIL t1_busy_fall got=%b exp=0", busy); else pass_cnt++;
      chk_cnt++; if (d_o !== 8'hA5) $display("FAIL t1_d_hold got=%h exp=a5", d_o); else pass_cnt++;
   endtask

   task automatic test_round_robin();
      int unsigned n, rc;
      bit to;
      logic [1:0] want;
      idle_all();
      req_v = 4'b1111;
      req_d = 32'h4433_2211;
      apply_reset();
      for (int k = 0; k < 6; k++) begin
         want = 2'(k % 4);
         n = 0;
         while (req_rdy === 4'b0000 && n < 20) begin tick(); n++; end
         chk_cnt++; if (req_rdy !== (4'b0001 << want)) $display("FAIL rr_req_rdy k=%0d got=%b exp=%b", k, req_rdy, 4'b0001 << want); else pass_cnt++;
         tick();
         chk_cnt++; if (grant_id !== want) $display("FAIL rr_grant_id k=%0d got=%0d exp=%0d", k, grant_id, want); else pass_cnt++;
         chk_cnt++; if (d_o !== 8'(8'h11 * (want + 1))) $display("FAIL rr_d_o k=%0d got=%h exp=%h", k, d_o, 8'(8'h11 * (want + 1))); else pass_cnt++;
         hs_main(to, rc);
         chk_cnt++; if (to !== 1'b0) $display("FAIL rr_handshake_timeout k=%0d got=%b exp=0", k, to); else pass_cnt++;
         chk_cnt++; if (rc !== 0) $display("FAIL rr_extra_rdy k=%0d got=%0d exp=0", k, rc); else pass_cnt++;
      end
   endtask

   task automatic test_ack_high_reset();
      int unsigned rc;
      bit to;
      idle_all();
      a_o = 1'b1;
      req_v = 4'b0001;
      req_d = 32'h0000_007E;
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         tick();
         chk_cnt++; if (req_rdy !== 4'b0000) $display("FAIL ackhi_req_rdy i=%0d got=%b exp=0000", i, req_rdy); else pass_cnt++;
         chk_cnt++; if (r_o !== 1'b0) $display("FAIL ackhi_r_o i=%0d got=%b exp=0", i, r_o); else pass_cnt++;
      end
      a_o = 1'b0;
      tick();
      chk_cnt++; if (req_rdy !== 4'b0000) $display("FAIL ackhi_early_rdy got=%b exp=0000", req_rdy); else pass_cnt++;
      tick();
      chk_cnt++; if (req_rdy !== 4'b0001) $display("FAIL ackhi_rdy got=%b exp=0001", req_rdy); else pass_cnt++;
      tick();
      req_v = 4'b0000;
      chk_cnt++; if (grant_id !== 2'd0 || d_o !== 8'h7E) $display("FAIL ackhi_grant id=%0d d=%h exp id=0 d=7e", grant_id, d_o); else pass_cnt++;
      hs_main(to, rc);
      chk_cnt++; if (to !== 1'b0) $display("FAIL ackhi_timeout got=%b exp=0", to); else pass_cnt++;
   endtask

   task automatic test_setup3();
      int unsigned n;
      bit to;
      idle_all();
      v3 = 4'b0010;
      d3 = 32'h0000_5C00;
      apply_reset();
      n = 0;
      while (rdy3 === 4'b0000 && n < 20) begin tick(); n++; end
      chk_cnt++; if (rdy3 !== 4'b0010) $display("FAIL s3_rdy got=%b exp=0010", rdy3); else pass_cnt++;
      tick();
      chk_cnt++; if (do3 !== 8'h5C || r3 !== 1'b0) $display("FAIL s3_grant d=%h r=%b exp d=5c r=0", do3, r3); else pass_cnt++;
      v3 = 4'b0000;
      d3 = 32'hFFFF_FFFF;
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk_cnt++; if (r3 !== (i == 3)) $display("FAIL s3_r_edge%0d got=%b exp=%b", i, r3, (i == 3)); else pass_cnt++;
         chk_cnt++; if (do3 !== 8'h5C) $display("FAIL s3_d_stable%0d got=%h exp=5c", i, do3); else pass_cnt++;
      end
      hs_s3(to);
      chk_cnt++; if (to !== 1'b0) $display("FAIL s3_timeout got=%b exp=0", to); else pass_cnt++;
      chk_cnt++; if (do3 !== 8'h5C) $display("FAIL s3_d_after got=%h exp=5c", do3); else pass_cnt++;
      v3 = 4'b0001;
      d3 = 32'h0000_003E;
      n = 0;
      while (rdy3 === 4'b0000 && n < 20) begin tick(); n++; end
      tick();
      v3 = 4'b0000;
      chk_cnt++; if (do3 !== 8'h3E || gid3 !== 2'd0) $display("FAIL s3_next d=%h id=%0d exp d=3e id=0", do3, gid3); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int unsigned n, rc;
      bit to;
      idle_all();
      req_v = 4'b0100;
      req_d = 32'h00A5_0000;
      apply_reset();
      n = 0;
      while (req_rdy === 4'b0000 && n < 20) begin tick(); n++; end
      tick();
      req_v = 4'b0000;
      n = 0;
      while (r_o !== 1'b1 && n < 20) begin tick(); n++; end
      chk_cnt++; if (r_o !== 1'b1) $display("FAIL mid_in_req got=%b exp=1", r_o); else pass_cnt++;
      #3;
      rst = 1'b0;
      #1;
      chk_cnt++; if (r_o !== 1'b0) $display("FAIL mid_r_o got=%b exp=0", r_o); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL mid_busy got=%b exp=0", busy); else pass_cnt++;
      chk_cnt++; if (d_o !== 8'h00) $display("FAIL mid_d_o got=%h exp=00", d_o); else pass_cnt++;
      tick();
      req_v = 4'b1111;
      req_d = 32'h4433_2211;
      rst = 1'b1;
      n = 0;
      while (req_rdy === 4'b0000 && n < 20) begin tick(); n++; end
      chk_cnt++; if (req_rdy !== 4'b0001) $display("FAIL mid_ptr_rdy got=%b exp=0001", req_rdy); else pass_cnt++;
      tick();
      chk_cnt++; if (grant_id !== 2'd0 || d_o !== 8'h11) $display("FAIL mid_ptr_grant id=%0d d=%h exp id=0 d=11", grant_id, d_o); else pass_cnt++;
      req_v = 4'b0000;
      hs_main(to, rc);
      chk_cnt++; if (to !== 1'b0) $display("FAIL mid_timeout got=%b exp=0", to); else pass_cnt++;
   endtask

   task automatic test_nreq3_skip();
      int unsigned n, rc;
      bit to;
      logic [1:0] want;
      idle_all();
      vn = 3'b101;
      dn = 24'hC2_B1_A0;
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         want = (k % 2 == 0) ? 2'd0 : 2'd2;
         n = 0;
         while (rdyn === 3'b000 && n < 20) begin tick(); n++; end
         chk_cnt++; if (rdyn !== (3'b001 << want)) $display("FAIL n3_rdy k=%0d got=%b exp=%b", k, rdyn, 3'b001 << want); else pass_cnt++;
         tick();
         chk_cnt++; if (gidn !== want) $display("FAIL n3_grant_id k=%0d got=%0d exp=%0d", k, gidn, want); else pass_cnt++;
         chk_cnt++; if (don !== ((want == 2'd0) ? 8'hA0 : 8'hC2)) $display("FAIL n3_d_o k=%0d got=%h exp=%h", k, don, (want == 2'd0) ? 8'hA0 : 8'hC2); else pass_cnt++;
         hs_n3(to, rc);
         chk_cnt++; if (to !== 1'b0 || rc !== 0) $display("FAIL n3_handshake k=%0d timeout=%b extra_rdy=%0d exp 0/0", k, to, rc); else pass_cnt++;
      end
   endtask

   initial begin
      rst = 1'b0;
      idle_all();
      test_reset();
      test_round_robin();
      test_ack_high_reset();
      test_setup3();
      test_reset_mid();
      test_nreq3_skip();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
